// File: rtl/receptor_display_if.sv
// Display link bundle: serial input lines toward the responder and its frame-memory write port.
interface receptor_display_if;
    logic       io_sclk;
    logic       io_sdin;
    logic       io_cs;
    logic       io_dc;
    logic       io_reset;
    logic       fb_we;
    logic [8:0] fb_addr;
    logic [7:0] fb_wdata;
    logic       frame_done;

    modport master (
        output io_sclk, io_sdin, io_cs, io_dc, io_reset,
        input  fb_we, fb_addr, fb_wdata, frame_done
    );

    modport slave (
        input  io_sclk, io_sdin, io_cs, io_dc, io_reset,
        output fb_we, fb_addr, fb_wdata, frame_done
    );
endinterface

// File: rtl/receptor_display.sv
// PCD8544-class serial display responder: deserialises the link, writes data bytes to frame memory
// and decodes command bytes into addressing and mode registers.
module receptor_display #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned COLS        = 84,
    parameter int unsigned BANKS       = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    receptor_display_if.slave bus,
    output logic [6:0]        x_addr,
    output logic [2:0]        y_addr,
    output logic              power_down,
    output logic              v_mode,
    output logic              h_mode,
    output logic [1:0]        disp_mode,
    output logic [6:0]        vop,
    output logic [2:0]        bias,
    output logic              err_incomplete
);

    localparam int unsigned NSIG  = 5;
    localparam int unsigned I_SCK = 0;
    localparam int unsigned I_SDI = 1;
    localparam int unsigned I_DC  = 2;
    localparam int unsigned I_CS  = 3;
    localparam int unsigned I_RST = 4;
    // cs idles inactive (high); display reset idles asserted until the line is seen high
    localparam logic [NSIG-1:0] SYNC_RST = 5'b01000;
    localparam logic [6:0]      LAST_X   = 7'(COLS - 1);
    localparam logic [2:0]      LAST_Y   = 3'(BANKS - 1);

    logic [NSIG-1:0] r_sync [SYNC_STAGES];
    logic            r_sclk_d;
    logic [NSIG-1:0] w_in;
    logic [NSIG-1:0] w_s;
    logic            w_edge;
    logic [7:0]      w_byte;
    logic [8:0]      w_lin;

    logic [2:0] r_cnt,   n_cnt;
    logic [7:0] r_shift, n_shift;
    logic [6:0] r_x,     n_x;
    logic [2:0] r_y,     n_y;
    logic       r_pd,    n_pd;
    logic       r_v,     n_v;
    logic       r_h,     n_h;
    logic [1:0] r_disp,  n_disp;
    logic [6:0] r_vop,   n_vop;
    logic [2:0] r_bias,  n_bias;
    logic       r_fb_we, n_fb_we;
    logic [8:0] r_fb_addr, n_fb_addr;
    logic [7:0] r_fb_wdata, n_fb_wdata;
    logic       r_frame_done, n_frame_done;
    logic       r_err,   n_err;

    assign w_in = {bus.io_reset, bus.io_cs, bus.io_dc, bus.io_sdin, bus.io_sclk};

    // Synchronizer chain plus one delay flop on sclk for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) r_sync[i] <= SYNC_RST;
            r_sclk_d <= 1'b0;
        end else begin
            r_sync[0] <= w_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) r_sync[i] <= r_sync[i-1];
            r_sclk_d <= r_sync[SYNC_STAGES-1][I_SCK];
        end
    end

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_edge = w_s[I_SCK] & ~r_sclk_d;
    assign w_byte = {r_shift[6:0], w_s[I_SDI]};
    assign w_lin  = 9'(r_y) * 9'(COLS) + 9'(r_x);

    // Next-state: deserialiser, write/advance, command decode
    always_comb begin
        n_cnt        = r_cnt;
        n_shift      = r_shift;
        n_x          = r_x;
        n_y          = r_y;
        n_pd         = r_pd;
        n_v          = r_v;
        n_h          = r_h;
        n_disp       = r_disp;
        n_vop        = r_vop;
        n_bias       = r_bias;
        n_fb_we      = 1'b0;
        n_fb_addr    = r_fb_addr;
        n_fb_wdata   = r_fb_wdata;
        n_frame_done = 1'b0;
        n_err        = 1'b0;

        if (!w_s[I_RST]) begin
            n_cnt      = 3'd0;
            n_shift    = 8'd0;
            n_x        = 7'd0;
            n_y        = 3'd0;
            n_pd       = 1'b1;
            n_v        = 1'b0;
            n_h        = 1'b0;
            n_disp     = 2'd0;
            n_vop      = 7'd0;
            n_bias     = 3'd0;
            n_fb_addr  = 9'd0;
            n_fb_wdata = 8'd0;
        end else if (w_s[I_CS]) begin
            n_cnt   = 3'd0;
            n_shift = 8'd0;
            n_err   = (r_cnt != 3'd0);
        end else if (w_edge) begin
            n_shift = w_byte;
            n_cnt   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
                n_shift = 8'd0;
                if (w_s[I_DC]) begin
                    n_fb_we      = 1'b1;
                    n_fb_addr    = w_lin;
                    n_fb_wdata   = w_byte;
                    n_frame_done = (r_x == LAST_X) && (r_y == LAST_Y);
                    if (!r_v) begin
                        if (r_x == LAST_X) begin
                            n_x = 7'd0;
                            n_y = (r_y == LAST_Y) ? 3'd0 : r_y + 3'd1;
                        end else begin
                            n_x = r_x + 7'd1;
                        end
                    end else begin
                        if (r_y == LAST_Y) begin
                            n_y = 3'd0;
                            n_x = (r_x == LAST_X) ? 7'd0 : r_x + 7'd1;
                        end else begin
                            n_y = r_y + 3'd1;
                        end
                    end
                end else if (w_byte[7:3] == 5'b00100) begin
                    n_pd = w_byte[2];
                    n_v  = w_byte[1];
                    n_h  = w_byte[0];
                end else if (!r_h) begin
                    if (w_byte[7:3] == 5'b00001) begin
                        n_disp = {w_byte[2], w_byte[0]};
                    end else if (w_byte[7:3] == 5'b01000) begin
                        if (32'(w_byte[2:0]) < BANKS) n_y = w_byte[2:0];
                    end else if (w_byte[7]) begin
                        if (32'(w_byte[6:0]) < COLS) n_x = w_byte[6:0];
                    end
                end else begin
                    if (w_byte[7:3] == 5'b00010) begin
                        n_bias = w_byte[2:0];
                    end else if (w_byte[7]) begin
                        n_vop = w_byte[6:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= 3'd0;
            r_shift      <= 8'd0;
            r_x          <= 7'd0;
            r_y          <= 3'd0;
            r_pd         <= 1'b1;
            r_v          <= 1'b0;
            r_h          <= 1'b0;
            r_disp       <= 2'd0;
            r_vop        <= 7'd0;
            r_bias       <= 3'd0;
            r_fb_we      <= 1'b0;
            r_fb_addr    <= 9'd0;
            r_fb_wdata   <= 8'd0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_cnt        <= n_cnt;
            r_shift      <= n_shift;
            r_x          <= n_x;
            r_y          <= n_y;
            r_pd         <= n_pd;
            r_v          <= n_v;
            r_h          <= n_h;
            r_disp       <= n_disp;
            r_vop        <= n_vop;
            r_bias       <= n_bias;
            r_fb_we      <= n_fb_we;
            r_fb_addr    <= n_fb_addr;
            r_fb_wdata   <= n_fb_wdata;
            r_frame_done <= n_frame_done;
            r_err        <= n_err;
        end
    end

    assign bus.fb_we      = r_fb_we;
    assign bus.fb_addr    = r_fb_addr;
    assign bus.fb_wdata   = r_fb_wdata;
    assign bus.frame_done = r_frame_done;
    assign x_addr         = r_x;
    assign y_addr         = r_y;
    assign power_down     = r_pd;
    assign v_mode         = r_v;
    assign h_mode         = r_h;
    assign disp_mode      = r_disp;
    assign vop            = r_vop;
    assign bias           = r_bias;
    assign err_incomplete = r_err;

endmodule

// File: tb/tb_receptor_display.sv
// Scoreboard bench for receptor_display: directed scenarios plus randomized traffic vs a linear-address model.
module tb_receptor_display;

    localparam int unsigned COLS  = 84;
    localparam int unsigned BANKS = 6;
    localparam int unsigned HALF  = 4;
    localparam int unsigned FRAME = COLS * BANKS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    receptor_display_if u_if();

    logic [6:0] x_addr;
    logic [2:0] y_addr;
    logic       power_down, v_mode, h_mode, err_incomplete;
    logic [1:0] disp_mode;
    logic [6:0] vop;
    logic [2:0] bias;

    receptor_display #(.SYNC_STAGES(2), .COLS(COLS), .BANKS(BANKS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (u_if.slave),
        .x_addr         (x_addr),
        .y_addr         (y_addr),
        .power_down     (power_down),
        .v_mode         (v_mode),
        .h_mode         (h_mode),
        .disp_mode      (disp_mode),
        .vop            (vop),
        .bias           (bias),
        .err_incomplete (err_incomplete)
    );

    typedef struct packed {
        logic [8:0] addr;
        logic [7:0] data;
        logic       fd;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  err_seen = 0;
    int  err_exp  = 0;
    int  fd_seen  = 0;

    // Reference model: pointer kept as a linear index in the current scan order
    int m_x, m_y, m_vop, m_bias, m_disp;
    bit m_pd, m_v, m_h;

    task automatic model_reset();
        m_x = 0; m_y = 0; m_vop = 0; m_bias = 0; m_disp = 0;
        m_pd = 1'b1; m_v = 1'b0; m_h = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b, input logic dc);
        int  v;
        int  lin;
        wr_t e;
        v = int'(b);
        if (dc) begin
            e.addr = 9'(m_y * COLS + m_x);
            e.data = b;
            if (!m_v) begin
                lin = (m_y * COLS + m_x + 1) % FRAME;
                m_x = lin % COLS;
                m_y = lin / COLS;
            end else begin
                lin = (m_x * BANKS + m_y + 1) % FRAME;
                m_x = lin / BANKS;
                m_y = lin % BANKS;
            end
            e.fd = (lin == 0);
            exp_q.push_back(e);
        end else if (v >= 32 && v <= 39) begin
            m_pd = b[2]; m_v = b[1]; m_h = b[0];
        end else if (!m_h) begin
            if (v >= 8 && v <= 15) m_disp = (v / 4 % 2) * 2 + (v % 2);
            else if (v >= 64 && v <= 71) begin
                if (v - 64 < BANKS) m_y = v - 64;
            end else if (v >= 128) begin
                if (v - 128 < COLS) m_x = v - 128;
            end
        end else begin
            if (v >= 16 && v <= 23) m_bias = v - 16;
            else if (v >= 128) m_vop = v - 128;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, ":x_addr"},     int'(x_addr),     m_x);
        chk({tag, ":y_addr"},     int'(y_addr),     m_y);
        chk({tag, ":power_down"}, int'(power_down), int'(m_pd));
        chk({tag, ":v_mode"},     int'(v_mode),     int'(m_v));
        chk({tag, ":h_mode"},     int'(h_mode),     int'(m_h));
        chk({tag, ":disp_mode"},  int'(disp_mode),  m_disp);
        chk({tag, ":vop"},        int'(vop),        m_vop);
        chk({tag, ":bias"},       int'(bias),       m_bias);
    endtask

    task automatic send_bit(input logic b, input logic dc);
        @(posedge clk);
        u_if.io_sdin = b;
        u_if.io_dc   = dc;
        repeat (HALF) @(posedge clk);
        u_if.io_sclk = 1'b1;
        repeat (HALF) @(posedge clk);
        u_if.io_sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input logic dc);
        for (int i = 7; i > 7 - n; i--) send_bit(b[i], dc);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        model_byte(b, dc);
        send_bits(b, 8, dc);
    endtask

    task automatic cs_low();
        @(posedge clk);
        u_if.io_cs = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic cs_high();
        repeat (2) @(posedge clk);
        u_if.io_cs = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: pop and compare every frame-memory write
    always @(negedge clk) begin
        wr_t e;
        if (u_if.fb_we) begin
            n_checks++;
            if (u_if.frame_done) fd_seen++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL fb_write unexpected addr=%0d data=%h", u_if.fb_addr, u_if.fb_wdata);
            end else begin
                e = exp_q.pop_front();
                if (u_if.fb_addr != e.addr || u_if.fb_wdata != e.data || u_if.frame_done != e.fd) begin
                    n_errors++;
                    $display("FAIL fb_write actual addr=%0d data=%h fd=%b required addr=%0d data=%h fd=%b",
                             u_if.fb_addr, u_if.fb_wdata, u_if.frame_done, e.addr, e.data, e.fd);
                end
            end
        end else if (u_if.frame_done) begin
            n_errors++;
            $display("FAIL frame_done actual=1 required=0 (no write)");
        end
        if (err_incomplete) err_seen++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int         r;
        u_if.io_sclk  = 1'b0;
        u_if.io_sdin  = 1'b0;
        u_if.io_cs    = 1'b1;
        u_if.io_dc    = 1'b0;
        u_if.io_reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        settle();
        check_status("reset");
        chk("reset:fb_we", int'(u_if.fb_we), 0);

        // Init command sequence
        cs_low();
        send_byte(8'h21, 1'b0);
        send_byte(8'hBF, 1'b0);
        send_byte(8'h14, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h0C, 1'b0);
        settle();
        check_status("init");
        chk("init:vop_const",  int'(vop),        63);
        chk("init:bias_const", int'(bias),       4);
        chk("init:disp_const", int'(disp_mode),  2);
        chk("init:pd_const",   int'(power_down), 0);

        // Full frame, horizontal addressing
        fd_seen = 0;
        for (int i = 0; i < int'(FRAME); i++) send_byte(8'(i), 1'b1);
        settle();
        chk("frame:fd_count", fd_seen, 1);
        chk("frame:x_zero", int'(x_addr), 0);
        chk("frame:y_zero", int'(y_addr), 0);
        check_status("frame");

        // Vertical addressing
        send_byte(8'h22, 1'b0);
        send_byte(8'h80, 1'b0);
        send_byte(8'h40, 1'b0);
        for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1'b1);
        settle();
        chk("vert:x", int'(x_addr), 1);
        chk("vert:y", int'(y_addr), 1);
        check_status("vert");

        // Out-of-range address commands are ignored
        send_byte(8'h45, 1'b0);
        send_byte(8'h46, 1'b0);
        send_byte(8'hD4, 1'b0);
        settle();
        chk("range:y", int'(y_addr), 5);
        chk("range:x", int'(x_addr), 1);
        check_status("range");

        // Truncated byte then a clean one
        send_bits(8'hFF, 5, 1'b1);
        cs_high();
        err_exp++;
        cs_low();
        send_byte(8'hA5, 1'b1);
        settle();
        chk("trunc:err_count", err_seen, err_exp);
        chk("trunc:queue", exp_q.size(), 0);
        check_status("trunc");

        // Randomized mix of data, commands, cs gaps and truncated bytes
        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 45) begin
                send_byte(8'($urandom), 1'b1);
            end else if (r < 85) begin
                case ($urandom_range(0, 5))
                    0: b = 8'h20 + 8'($urandom_range(0, 7));
                    1: b = 8'h80 + 8'($urandom_range(0, 127));
                    2: b = 8'h40 + 8'($urandom_range(0, 7));
                    3: b = 8'h08 + 8'($urandom_range(0, 7));
                    4: b = 8'h10 + 8'($urandom_range(0, 7));
                    default: b = 8'($urandom);
                endcase
                send_byte(b, 1'b0);
            end else if (r < 92) begin
                cs_high();
                cs_low();
            end else begin
                send_bits(8'($urandom), int'($urandom_range(1, 7)), 1'($urandom));
                cs_high();
                err_exp++;
                cs_low();
            end
        end
        settle();
        check_status("random");
        chk("random:err_count", err_seen, err_exp);
        chk("random:queue", exp_q.size(), 0);

        // Display reset mid-byte
        send_bits(8'hE0, 3, 1'b1);
        u_if.io_reset = 1'b0;
        model_reset();
        settle();
        check_status("dreset_hold");
        u_if.io_reset = 1'b1;
        settle();
        check_status("dreset_release");
        send_byte(8'h3C, 1'b1);
        settle();
        check_status("dreset_next");
        cs_high();
        settle();
        chk("final:err_count", err_seen, err_exp);
        chk("final:queue", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
